// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequencing controller for the instruction-fetch stage.
//
// After reset the block owns the instruction-memory write port and accepts
// LOAD_WORDS program words from a loader. Once the last word is written it
// hands control to fetch. From then on it drives the PC load enable, the PC mux
// select and the IF/ID flush. These outputs follow the hazard-unit stall and
// the EX/MEM taken-branch decision (pcsrc).
//
// Parameters:
//   LOAD_WORDS   - words delivered by the loader before fetch starts (1..64)
//   FLUSH_CYCLES - IF/ID bubbles held after a taken branch (1..3)
//
// Ports:
//   clock, reset_n        - rising-edge clock, asynchronous active-low reset
//   ld_valid/ld_data      - loader word stream; ld_ready accepts it
//   mem_we/waddr/wdata    - instruction memory write port (combinational)
//   stall, pcsrc          - hazard-unit stall, taken branch from EX/MEM
//   pc_en, pc_sel         - PC/IF-ID load enable, PC mux (1 = branch target)
//   flush                 - registered IF/ID bubble request
//   boot_done             - sticky "program loaded" flag
//   state                 - LOAD=0, RUN=1, STALL=2, FLUSH=3
//   perf_stall/perf_flush - saturating performance counters
//
// Optional feature macro: FETCH_CTRL_PERF_EN. When it is defined, the perf
// counters are built. When it is undefined, both ports are tied to zero.

module fetch_ctrl #(
    parameter int unsigned LOAD_WORDS   = 18,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    output logic        mem_we,
    output logic [5:0]  mem_waddr,
    output logic [31:0] mem_wdata,
    input  logic        stall,
    input  logic        pcsrc,
    output logic        pc_en,
    output logic        pc_sel,
    output logic        flush,
    output logic        boot_done,
    output logic [1:0]  state,
    output logic [15:0] perf_stall,
    output logic [15:0] perf_flush
);

    typedef enum logic [1:0] {
        StLoad  = 2'd0,
        StRun   = 2'd1,
        StStall = 2'd2,
        StFlush = 2'd3
    } state_e;

    localparam logic [5:0] LastWord  = 6'(LOAD_WORDS - 1);
    localparam logic [1:0] FlushInit = 2'(FLUSH_CYCLES);

    state_e     state_q, state_d;
    logic [5:0] wcnt_q, wcnt_d;
    logic [1:0] fcnt_q, fcnt_d;
    logic       boot_done_q, boot_done_d;
    logic       flush_q, flush_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StLoad;
            wcnt_q      <= 6'd0;
            fcnt_q      <= 2'd0;
            boot_done_q <= 1'b0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            fcnt_q      <= fcnt_d;
            boot_done_q <= boot_done_d;
            flush_q     <= flush_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        fcnt_d      = fcnt_q;
        boot_done_d = boot_done_q;
        ld_ready    = 1'b0;
        mem_we      = 1'b0;
        pc_en       = 1'b0;
        pc_sel      = 1'b0;

        if (state_q == StLoad) begin
            ld_ready = 1'b1;
            // Gate with reset_n so no write strobe leaks out while reset is held.
            mem_we   = ld_valid & reset_n;
            if (ld_valid) begin
                wcnt_d = wcnt_q + 6'd1;
                if (wcnt_q == LastWord) begin
                    state_d     = StRun;
                    boot_done_d = 1'b1;
                end
            end
        end else begin
            pc_sel = pcsrc;
            // A taken branch must redirect the PC even when a stall is requested.
            pc_en  = pcsrc | ~stall;
            unique case (state_q)
                StRun: begin
                    if (pcsrc) begin
                        state_d = StFlush;
                        fcnt_d  = FlushInit;
                    end else if (stall) begin
                        state_d = StStall;
                    end
                end
                StStall: begin
                    if (pcsrc) begin
                        state_d = StFlush;
                        fcnt_d  = FlushInit;
                    end else if (!stall) begin
                        state_d = StRun;
                    end
                end
                StFlush: begin
                    if (pcsrc) begin
                        fcnt_d = FlushInit;
                    end else if (fcnt_q == 2'd1) begin
                        state_d = stall ? StStall : StRun;
                        fcnt_d  = 2'd0;
                    end else begin
                        fcnt_d = fcnt_q - 2'd1;
                    end
                end
                default: state_d = state_q;
            endcase
        end

        // Flush is high for exactly the cycles spent in FLUSH.
        flush_d = (state_d == StFlush);
    end

    assign mem_waddr = wcnt_q;
    assign mem_wdata = ld_data;
    assign flush     = flush_q;
    assign boot_done = boot_done_q;
    assign state     = state_q;

`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] perf_stall_q, perf_stall_d;
    logic [15:0] perf_flush_q, perf_flush_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_q <= 16'd0;
            perf_flush_q <= 16'd0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (state_q != StLoad) begin
            if (!pc_en && (perf_stall_q != 16'hFFFF)) begin
                perf_stall_d = perf_stall_q + 16'd1;
            end
            if (pcsrc && (perf_flush_q != 16'hFFFF)) begin
                perf_flush_d = perf_flush_q + 16'd1;
            end
        end
    end

    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
`else
    assign perf_stall = 16'd0;
    assign perf_flush = 16'd0;
`endif

endmodule
